cs_final_adder_pipe: RTL and testbench

//   Downstream stage of the 4:2 compressor tree: takes the final redundant row
//   (sum vector + aligned carry vector) and resolves it to a binary result.
//   Two-stage pipelined carry-propagate adder: low slice in stage 1, high slice

---
 rtl/cs_add_pkg.sv | 15 +
 rtl/cpa_slice.sv | 28 ++
 rtl/fa.sv | 13 +
 rtl/cs_final_adder_pipe.sv | 125 ++++++++++++
 tb/tb_cs_final_adder_pipe.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/cs_add_pkg.sv
// Shared constants and the stage-1 payload layout for the carry-save final adder.
package cs_add_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int SPLIT_DEF   = 8;
  localparam int COUNT_W_DEF = 16;

  typedef struct packed {
    logic [SPLIT_DEF-1:0]           lo_sum;
    logic                           lo_cout;
    logic [WIDTH_DEF-SPLIT_DEF-1:0] hi_sum;
    logic [WIDTH_DEF-SPLIT_DEF-1:0] hi_carry;
  } s1_payload_t;

endpackage

// File: rtl/cpa_slice.sv
// Combinational W-bit ripple-carry adder: {cout_o, s_o} = a_i + b_i + cin_i.
module cpa_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic         cout_o
);

  logic [W:0] c_s;

  assign c_s[0] = cin_i;

  for (genvar i = 0; i < W; i++) begin : g_bit
    fa u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (c_s[i]),
      .s_o (s_o[i]),
      .c_o (c_s[i+1])
    );
  end

  assign cout_o = c_s[W];

endmodule

// File: rtl/fa.sv
// Single-bit full adder cell used to build the ripple-carry slices.
module fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/cs_final_adder_pipe.sv
// Two-stage pipelined carry-propagate adder resolving a redundant sum/carry row;
// low slice added in stage 1, high slice plus the stored carry in stage 2.
module cs_final_adder_pipe
  import cs_add_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SPLIT   = SPLIT_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_sum,
  input  logic [WIDTH-1:0]   in_carry,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     out_result,
  output logic [COUNT_W-1:0] out_count
);

  localparam int HI_W = WIDTH - SPLIT;

  typedef struct packed {
    logic [SPLIT-1:0] lo_sum;
    logic             lo_cout;
    logic [HI_W-1:0]  hi_sum;
    logic [HI_W-1:0]  hi_carry;
  } s1_row_t;

  s1_row_t            s1_q, s1_d;
  logic               s1_valid_q, s1_valid_d;
  logic               s2_valid_q, s2_valid_d;
  logic [WIDTH:0]     result_q, result_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic               s1_adv_s, s2_adv_s;
  logic [SPLIT-1:0]   lo_s;
  logic               lo_c_s;
  logic [HI_W-1:0]    hi_s;
  logic               hi_c_s;

  cpa_slice #(.W(SPLIT)) u_lo (
    .a_i    (in_sum[SPLIT-1:0]),
    .b_i    (in_carry[SPLIT-1:0]),
    .cin_i  (1'b0),
    .s_o    (lo_s),
    .cout_o (lo_c_s)
  );

  cpa_slice #(.W(HI_W)) u_hi (
    .a_i    (s1_q.hi_sum),
    .b_i    (s1_q.hi_carry),
    .cin_i  (s1_q.lo_cout),
    .s_o    (hi_s),
    .cout_o (hi_c_s)
  );

  // Ready chain is combinational through out_ready; there is no skid buffer.
  assign s2_adv_s = !s2_valid_q || out_ready;
  assign s1_adv_s = !s1_valid_q || s2_adv_s;

  // Next-state for both pipeline stages and the output handshake counter.
  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    count_d    = count_q;

    if (s1_adv_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.lo_sum   = lo_s;
        s1_d.lo_cout  = lo_c_s;
        s1_d.hi_sum   = in_sum[WIDTH-1:SPLIT];
        s1_d.hi_carry = in_carry[WIDTH-1:SPLIT];
      end else begin
        s1_d = s1_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s2_adv_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = {hi_c_s, hi_s, s1_q.lo_sum};
      end else begin
        result_d = result_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end

    if (s2_valid_q && out_ready) begin
      count_d = count_q + COUNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Pipeline and counter registers; reset drops any in-flight rows.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      count_q    <= '0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      count_q    <= count_d;
    end
  end

  assign in_ready   = s1_adv_s;
  assign out_valid  = s2_valid_q;
  assign out_result = result_q;
  assign out_count  = count_q;

endmodule

// File: tb/tb_cs_final_adder_pipe.sv
// Directed and randomized bench for cs_final_adder_pipe (COUNT_W=4 to exercise wrap).
module tb_cs_final_adder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_sum;
  logic [15:0] in_carry;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_result;
  logic [3:0]  out_count;

  int errors = 0;
  int checks = 0;
  logic [16:0] sbq[$];
  int exp_cnt = 0;

  always #5 clk = ~clk;

  cs_final_adder_pipe #(.WIDTH(16), .SPLIT(8), .COUNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_count  (out_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // Scoreboard bookkeeping for this cycle, then advance to just after the next edge.
  task automatic tick();
    #1;
    if (rst) begin
      sbq.delete();
      exp_cnt = 0;
    end else begin
      check("count", {28'd0, out_count}, exp_cnt);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("spurious_out", 32'd1, 32'd0);
        end else begin
          check("sb_result", {15'd0, out_result}, {15'd0, sbq.pop_front()});
        end
        exp_cnt = (exp_cnt + 1) % 16;
      end
      if (in_valid && in_ready) begin
        sbq.push_back({1'b0, in_sum} + {1'b0, in_carry});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] s, input logic [15:0] c);
    in_valid = v;
    in_sum   = s;
    in_carry = c;
  endtask

  logic [16:0] exp3 [4];

  initial begin
    exp3[0] = 17'd3; exp3[1] = 17'd7; exp3[2] = 17'd11; exp3[3] = 17'd15;
    rst = 1'b1; out_ready = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000);
    @(posedge clk); #1;
    tick();
    rst = 1'b0;
    settle();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", {15'd0, out_result}, 32'd0);
    check("rst_out_count", {28'd0, out_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: carry crosses the split boundary, latency N+2
    out_ready = 1'b1;
    drive(1'b1, 16'h00FF, 16'h0001);
    tick();
    drive(1'b0, 16'h0000, 16'h0000);
    check("t1_valid_n1", {31'd0, out_valid}, 32'd0);
    tick();
    check("t1_valid_n2", {31'd0, out_valid}, 32'd1);
    check("t1_result", {15'd0, out_result}, 32'h00100);
    tick();
    check("t1_count", {28'd0, out_count}, 32'd1);

    // 2: all-ones operands then zero
    drive(1'b1, 16'hFFFF, 16'hFFFF);
    tick();
    drive(1'b1, 16'h0000, 16'h0000);
    tick();
    drive(1'b0, 16'h0000, 16'h0000);
    check("t2_max", {15'd0, out_result}, 32'h1FFFE);
    tick();
    check("t2_zero_valid", {31'd0, out_valid}, 32'd1);
    check("t2_zero", {15'd0, out_result}, 32'h0);
    tick();

    // 3: back-to-back rows at full throughput
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(2*i+1), 16'(2*i+2));
      settle();
      check("t3_in_ready", {31'd0, in_ready}, 32'd1);
      if (i >= 2) check("t3_stream", {15'd0, out_result}, {15'd0, exp3[i-2]});
      tick();
    end
    drive(1'b0, 16'h0000, 16'h0000);
    check("t3_row2", {15'd0, out_result}, 32'd11);
    tick();
    check("t3_row3", {15'd0, out_result}, 32'd15);
    tick();
    check("t3_drained", {31'd0, out_valid}, 32'd0);

    // 4: backpressure, hold and in-order release
    out_ready = 1'b0;
    drive(1'b1, 16'd10, 16'd1);
    tick();
    drive(1'b1, 16'd20, 16'd2);
    settle();
    check("t4_ready_b", {31'd0, in_ready}, 32'd1);
    tick();
    drive(1'b1, 16'd30, 16'd3);
    settle();
    check("t4_ready_c", {31'd0, in_ready}, 32'd0);
    tick();
    check("t4_ready_c2", {31'd0, in_ready}, 32'd0);
    check("t4_hold1", {15'd0, out_result}, 32'd11);
    tick();
    check("t4_hold2", {15'd0, out_result}, 32'd11);
    out_ready = 1'b1;
    settle();
    check("t4_ready_release", {31'd0, in_ready}, 32'd1);
    tick();
    drive(1'b0, 16'h0000, 16'h0000);
    check("t4_second", {15'd0, out_result}, 32'd22);
    tick();
    check("t4_third", {15'd0, out_result}, 32'd33);
    tick();
    check("t4_empty", {31'd0, out_valid}, 32'd0);

    // 5: reset with both stages full
    out_ready = 1'b0;
    drive(1'b1, 16'd1, 16'd1);
    tick();
    drive(1'b1, 16'd2, 16'd2);
    tick();
    check("t5_full_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    drive(1'b1, 16'd5, 16'd5);
    tick();
    rst = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000);
    settle();
    check("t5_out_valid", {31'd0, out_valid}, 32'd0);
    check("t5_in_ready", {31'd0, in_ready}, 32'd1);
    check("t5_count", {28'd0, out_count}, 32'd0);
    out_ready = 1'b1;
    drive(1'b1, 16'd100, 16'd23);
    tick();
    drive(1'b0, 16'h0000, 16'h0000);
    tick();
    check("t5_next_row", {15'd0, out_result}, 32'h7B);
    tick();

    // 6: counter wrap at 16
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 16'(i), 16'(3*i));
      tick();
    end
    drive(1'b0, 16'h0000, 16'h0000);
    tick();
    tick();
    check("t6_wrap", {28'd0, out_count}, 32'd1);

    // Random valid/ready with random operands against the scoreboard
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drive(1'b0, 16'h0000, 16'h0000);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("rand_drained", sbq.size(), 32'd0);
    check("rand_idle", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
